// File: rtl/popcnt_pkg.sv
// Shared definitions for the fixed-weight combination generator:
// vector width, index counter width, FSM states and a mask helper.
package popcnt_pkg;

    localparam int W     = 12;
    localparam int CNT_W = 10;   // C(12,6) = 924 fits in 10 bits

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Lowest-valued vector of weight k: k ones packed at the bottom.
    function automatic logic [W-1:0] low_mask(input logic [3:0] k);
        logic [W:0] m;
        m = ({{W{1'b0}}, 1'b1} << k) - {{W{1'b0}}, 1'b1};
        return m[W-1:0];
    endfunction

endpackage

// File: rtl/lsb_index12.sv
// 12-bit priority encoder: index of the lowest set bit (count of trailing
// zeros). An all-zero input yields 0; the caller never relies on that case.
module lsb_index12 (
    input  logic [11:0] vec,
    output logic [3:0]  idx
);

    // Scan from the top down so the lowest set bit is the last to win.
    always_comb begin
        // NOTE: default assignment first so no path leaves idx unassigned (no latch).
        idx = 4'd0;
        for (int i = 11; i >= 0; i--) begin
            if (vec[i]) idx = 4'(i);
        end
    end

endmodule

// File: rtl/popgen12.sv
// Enumerates every 12-bit vector of a requested popcount in ascending order,
// one vector per accepted output handshake, using Gosper's next-combination
// step. Invalid weight codes are accepted, flagged on err, and dropped.
module popgen12
    import popcnt_pkg::*;
#(
    parameter int W     = popcnt_pkg::W,
    parameter int CNT_W = popcnt_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [W:0]       req_onehot,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_data,
    output logic             out_last,
    output logic [CNT_W-1:0] out_index,
    output logic             err
);

    localparam logic [W:0]       ONE_CODE = 1;
    localparam logic [W-1:0]     ONE_VEC  = 1;
    localparam logic [CNT_W-1:0] ONE_IDX  = 1;

    state_t           state;
    logic [W-1:0]     data;
    logic [3:0]       weight;
    logic [CNT_W-1:0] index;
    logic             err_q;

    logic             code_ok;
    logic [3:0]       code_k;
    logic [W-1:0]     lsb;
    logic [W-1:0]     ripple;
    logic [W-1:0]     next_vec;
    logic [W-1:0]     last_vec;
    logic [3:0]       tz;
    logic             is_last;

    // A code is valid only when exactly one bit is set.
    assign code_ok = (req_onehot != '0) && ((req_onehot & (req_onehot - ONE_CODE)) == '0);

    // One-hot to binary weight; only meaningful when code_ok is set.
    always_comb begin
        code_k = 4'd0;
        for (int i = 0; i <= W; i++) begin
            if (req_onehot[i]) code_k = 4'(i);
        end
    end

    lsb_index12 u_lsb_index (
        .vec (data),
        .idx (tz)
    );

    // Gosper step: isolate lowest one, ripple it upward, then refill the
    // displaced ones at the bottom with shifts instead of a divide.
    assign lsb      = data & (~data + ONE_VEC);
    assign ripple   = data + lsb;
    assign next_vec = (((ripple ^ data) >> 2) >> tz) | ripple;

    // Final vector of the sequence: the k ones packed at the top.
    assign last_vec = low_mask(weight) << (W - int'(weight));
    assign is_last  = (data == last_vec);

    assign req_ready = (state == IDLE);
    assign out_valid = (state == RUN);
    assign out_data  = data;
    assign out_last  = (state == RUN) && is_last;
    assign out_index = index;
    assign err       = err_q;

    // Request acceptance, sequence stepping and err pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: every register, including the vector, is reset so a reset mid-sequence leaves no stale output.
        if (!rst_n) begin
            state  <= IDLE;
            data   <= '0;
            weight <= 4'd0;
            index  <= '0;
            err_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            err_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        if (code_ok) begin
                            state  <= RUN;
                            data   <= low_mask(code_k);
                            weight <= code_k;
                            index  <= '0;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (out_ready) begin
                        if (is_last) begin
                            state <= IDLE;
                        end else begin
                            data  <= next_vec;
                            index <= index + ONE_IDX;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_popgen12.sv
// Scoreboard bench for popgen12: stimulus pushes the expected vector stream
// from a brute-force popcount model; a negedge monitor pops on each transfer.
module tb_popgen12;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [12:0] req_onehot = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [11:0] out_data;
    logic        out_last;
    logic [9:0]  out_index;
    logic        err;

    typedef struct {
        logic [11:0] data;
        logic [9:0]  index;
        logic        last;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    popgen12 dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_onehot (req_onehot),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .out_index  (out_index),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: every 12-bit value of popcount k, ascending.
    task automatic push_expected(input int k);
        int   total = 0;
        int   n = 0;
        exp_t e;
        for (int v = 0; v < 4096; v++) if ($countones(v) == k) total++;
        for (int v = 0; v < 4096; v++) begin
            if ($countones(v) == k) begin
                e.data  = 12'(v);
                e.index = 10'(n);
                e.last  = (n == total - 1);
                sb_q.push_back(e);
                n++;
            end
        end
    endtask

    // Present one request; returns #1 after the accepting edge.
    task automatic send(input logic [12:0] code);
        int n = 0;
        while (!req_ready && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        check("req_ready_wait", req_ready, 1);
        req_onehot = code;
        req_valid  = 1'b1;
        @(posedge clk); #1;
        req_valid  = 1'b0;
        req_onehot = '0;
    endtask

    // Wait for the scoreboard to empty, then confirm return to IDLE.
    task automatic drain(input string name);
        int n = 0;
        while (sb_q.size() != 0 && n < 3000) begin
            @(posedge clk);
            n++;
        end
        check({name, "_drained"}, sb_q.size(), 0);
        @(negedge clk);
        check({name, "_ready_after"}, req_ready, 1);
        check({name, "_idle_after"}, out_valid, 0);
        @(posedge clk); #1;
    endtask

    // Monitor: compare every output transfer against the scoreboard head.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got data 0x%0h index %0d, expected no vector", out_data, out_index);
            end else begin
                mon_e = sb_q.pop_front();
                check("data", out_data, mon_e.data);
                check("index", out_index, mon_e.index);
                check("last", out_last, mon_e.last);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        logic [12:0] bad_codes [2];
        bad_codes[0] = 13'h006;
        bad_codes[1] = 13'h000;

        // Reset state
        #12;
        check("rst_req_ready", req_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_last", out_last, 0);
        check("rst_out_index", out_index, 0);
        check("rst_err", err, 0);
        @(posedge clk); #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;

        // k=2: 66 vectors, first one presented with latency 1
        push_expected(2);
        send(13'h004);
        @(negedge clk);
        check("k2_first_valid", out_valid, 1);
        check("k2_first_data", out_data, 12'h003);
        drain("k2");

        // k=0 and k=12: single-vector sequences
        push_expected(0);
        send(13'h001);
        drain("k0");
        push_expected(12);
        send(13'h1000);
        drain("k12");

        // Invalid codes: err pulse only, no output
        for (int i = 0; i < 2; i++) begin
            send(bad_codes[i]);
            @(negedge clk);
            check("bad_err_pulse", err, 1);
            check("bad_no_valid", out_valid, 0);
            check("bad_ready", req_ready, 1);
            @(negedge clk);
            check("bad_err_clear", err, 0);
            check("bad_still_idle", out_valid, 0);
            @(posedge clk); #1;
        end

        // k=3: backpressure while 0x00B is shown
        push_expected(3);
        send(13'h008);
        @(posedge clk); #1;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("hold_data", out_data, 12'h00B);
            check("hold_index", out_index, 1);
            check("hold_valid", out_valid, 1);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        drain("k3");

        // k=6: full 924-vector sequence
        push_expected(6);
        send(13'h040);
        drain("k6");

        // Reset in the middle of a k=4 sequence at index 10
        push_expected(4);
        send(13'h010);
        n = 0;
        while (out_index != 10'd10 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("mid_reached_idx10", out_index, 10);
        rst_n = 1'b0;
        #1;
        check("mid_rst_req_ready", req_ready, 1);
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_out_data", out_data, 0);
        check("mid_rst_out_last", out_last, 0);
        check("mid_rst_out_index", out_index, 0);
        check("mid_rst_err", err, 0);
        sb_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("post_rst_quiet", out_valid, 0);
        end
        @(posedge clk); #1;

        // Fresh k=1 request after reset
        push_expected(1);
        send(13'h002);
        @(negedge clk);
        check("k1_first_data", out_data, 12'h001);
        drain("k1");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/popgen12.md
POPGEN12 -- requirements
Module: popgen12

Interface
REQ-001 SHALL have parameter W, default 12, meaning vector width; only 12 is supported.
REQ-002 SHALL have parameter CNT_W, default 10, meaning index counter width, enough for C(12,6)=924.
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 req_valid  input  1  request present.
REQ-006 req_ready  output  1  block is idle and accepts a request.
REQ-007 req_onehot  input  W+1  one-hot weight code; bit k set means weight k, k in 0..12.
REQ-008 out_valid  output  1  out_data holds a valid vector.
REQ-009 out_ready  input  1  consumer accepts the vector.
REQ-010 out_data  output  W  current vector; popcount always equals the requested weight.
REQ-011 out_last  output  1  out_data is the final vector of the sequence.
REQ-012 out_index  output  CNT_W  zero-based ordinal of out_data within the sequence.
REQ-013 err  output  1  one-cycle pulse when a request with an invalid code is accepted.

Function
REQ-014 SHALL emit, for an accepted weight k, every W-bit vector of popcount k exactly once, in ascending numeric order.
REQ-015 SHALL implement a two-state FSM: IDLE (req_ready=1, out_valid=0) and RUN (req_ready=0, out_valid=1).
REQ-016 Request acceptance SHALL be req_valid&&req_ready in IDLE; a valid code moves the FSM to RUN.
REQ-017 First vector SHALL be (1<<k)-1 with out_index=0, presented in the cycle after acceptance (latency 1).
REQ-018 Output transfer SHALL be out_valid&&out_ready; out_data, out_last and out_index SHALL hold while out_ready is low.
REQ-019 On a non-last transfer, the next vector SHALL appear in the following cycle (no bubbles), and out_index SHALL increment by 1.
REQ-020 Next vector SHALL be the next-combination step (Gosper): c=x&-x; r=x+c; next=(((r^x)>>2)>>ctz(x))|r, using shifts only, with no divider.
REQ-021 out_last SHALL be 1 iff out_data == ((1<<k)-1)<<(W-k); the successor is never computed past this vector.
REQ-022 k=0 SHALL yield exactly one vector, 0, with out_last=1; k=12 SHALL yield exactly one vector, 0xFFF, with out_last=1.
REQ-023 On transfer of the last vector, the FSM SHALL return to IDLE; req_ready SHALL be 1 in the next cycle.
REQ-024 A req_onehot value that is zero or has more than one bit set SHALL be accepted, SHALL pulse err for one cycle (the cycle after acceptance), SHALL produce no output, and the FSM SHALL stay IDLE.
REQ-025 The final index SHALL equal C(12,k)-1.

Reset
REQ-026 Asserting rst_n low SHALL immediately force IDLE, req_ready=1, out_valid=0, out_data=0, out_last=0, out_index=0 and err=0.
REQ-027 Reset mid-sequence SHALL abandon the sequence; no vector follows deassertion until a new request is accepted.

Structure
REQ-028 W, CNT_W and the FSM state enumeration SHALL live in shared package popcnt_pkg.
REQ-029 Count-trailing-zeros SHALL be a separate sub-module, lsb_index12: a 12-bit priority encoder giving a 4-bit index.
REQ-030 Code validity and weight decode (one-hot to 4-bit binary) SHALL be combinational inside popgen12.
REQ-031 Only the FSM, vector, weight, index and err SHALL be registered.

Verification
REQ-032 req_onehot=13'h004 (k=2), out_ready=1 -> 0x003, 0x005, 0x006, 0x009 ...; 66 vectors; last is 0xC00 with out_index=65 and out_last=1.
REQ-033 req_onehot=13'h001 -> single 0x000 with out_last=1; req_onehot=13'h1000 -> single 0xFFF with out_last=1; req_ready returns 1 the cycle after each transfer.
REQ-034 req_onehot=13'h006 and 13'h000 -> err=1 for one cycle, out_valid stays 0, req_ready stays 1.
REQ-035 k=3: hold out_ready low 3 cycles while 0x00B is shown -> out_data/out_index stay constant; the next vector after release is 0x00D.
REQ-036 k=6 -> 924 vectors, all distinct, all of popcount 6 and strictly increasing; scoreboard checked against a reference model.
REQ-037 rst_n pulsed low while in RUN at out_index=10 -> outputs go to reset values asynchronously; a fresh k=1 request then yields 0x001 as its first vector.
